// File: rtl/alu_result_checker_pkg.sv
// Shared definitions for the ALU self-test loop: vector numbering, flag layout and
// the expected result of every stimulus vector.
package alu_result_checker_pkg;

  localparam int NUM_VECTORS       = 15;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int IDX_W             = 4;
  localparam int FLAG_W            = 5;

  // Flag word is {C,L,F,Z,N}, MSB..LSB.
  localparam int FLAG_C_BIT = 4;
  localparam int FLAG_L_BIT = 3;
  localparam int FLAG_F_BIT = 2;
  localparam int FLAG_Z_BIT = 1;
  localparam int FLAG_N_BIT = 0;

  localparam logic [FLAG_W-1:0] F_NONE = '0;
  localparam logic [FLAG_W-1:0] F_C    = FLAG_W'(1 << FLAG_C_BIT);
  localparam logic [FLAG_W-1:0] F_L    = FLAG_W'(1 << FLAG_L_BIT);
  localparam logic [FLAG_W-1:0] F_F    = FLAG_W'(1 << FLAG_F_BIT);
  localparam logic [FLAG_W-1:0] F_Z    = FLAG_W'(1 << FLAG_Z_BIT);
  localparam logic [FLAG_W-1:0] F_N    = FLAG_W'(1 << FLAG_N_BIT);

  typedef enum logic [IDX_W-1:0] {
    VEC_EXT_ADD = 4'd0,  VEC_ADD  = 4'd1,  VEC_XOR  = 4'd2,  VEC_SUB  = 4'd3,
    VEC_AND     = 4'd4,  VEC_OR   = 4'd5,  VEC_NOT  = 4'd6,  VEC_LSH  = 4'd7,
    VEC_RSH     = 4'd8,  VEC_ADDI = 4'd9,  VEC_SUBI = 4'd10, VEC_ANDI = 4'd11,
    VEC_ORI     = 4'd12, VEC_CMP  = 4'd13, VEC_CMPI = 4'd14
  } vec_idx_e;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COMPARE, S_DONE} state_e;

  typedef struct packed {
    logic [15:0]       exp_c;
    logic [FLAG_W-1:0] exp_flags;
    logic [FLAG_W-1:0] flag_mask;
  } rom_entry_t;

  // Logic ops do not define C/L/F, compares only define L/F/Z.
  localparam rom_entry_t EXP_TABLE [NUM_VECTORS] = '{
    '{16'h0008, F_NONE,    F_C | F_Z | F_N},  // EXT_ADD 5+3
    '{16'h0000, F_C | F_Z, F_C | F_Z | F_N},  // ADD FFFF+1
    '{16'h0000, F_Z,       F_Z | F_N},        // XOR 2^2
    '{16'h0004, F_NONE,    F_C | F_Z | F_N},  // SUB
    '{16'h0002, F_NONE,    F_Z | F_N},        // AND
    '{16'h00F7, F_NONE,    F_Z | F_N},        // OR
    '{16'hFF00, F_N,       F_Z | F_N},        // NOT
    '{16'h0010, F_NONE,    F_C | F_Z | F_N},  // LSH
    '{16'h0004, F_NONE,    F_C | F_Z | F_N},  // RSH
    '{16'h0105, F_NONE,    F_C | F_Z | F_N},  // ADDI
    '{16'hFFFE, F_C | F_N, F_C | F_Z | F_N},  // SUBI
    '{16'h000F, F_NONE,    F_Z | F_N},        // ANDI
    '{16'h00FF, F_NONE,    F_Z | F_N},        // ORI
    '{16'h0000, F_Z,       F_L | F_F | F_Z},  // CMP equal
    '{16'h0000, F_L,       F_L | F_F | F_Z}   // CMPI less
  };

endpackage

// File: rtl/alu_expect_rom.sv
// Combinational expected-value lookup by vector index; unknown indices read as all zeros.
module alu_expect_rom
  import alu_result_checker_pkg::*;
(
  input  logic [IDX_W-1:0]  idx,
  output logic [15:0]       exp_c,
  output logic [FLAG_W-1:0] exp_flags,
  output logic [FLAG_W-1:0] flag_mask
);

  rom_entry_t ent;

  always_comb begin
    ent = '0;
    if (idx < IDX_W'(NUM_VECTORS)) ent = EXP_TABLE[idx];
  end

  assign exp_c     = ent.exp_c;
  assign exp_flags = ent.exp_flags;
  assign flag_mask = ent.flag_mask;

endmodule

// File: rtl/alu_result_checker.sv
// Receive side of the ALU self-test loop: waits out the ALU settle time after each vector,
// compares C/FLAGS against the expected ROM and keeps per-pass statistics for the board display.
module alu_result_checker
  import alu_result_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VEC_STB,
  input  logic [IDX_W-1:0]  VEC_IDX,
  input  logic [15:0]       C,
  input  logic [FLAG_W-1:0] FLAGS,
  output logic              CHECK_STB,
  output logic              LAST_OK,
  output logic [IDX_W-1:0]  PASS_CNT,
  output logic [IDX_W-1:0]  FAIL_CNT,
  output logic              FAIL_SEEN,
  output logic [IDX_W-1:0]  FIRST_FAIL_IDX,
  output logic              OVERRUN,
  output logic              DONE
);

  localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
  localparam logic [IDX_W-1:0] CNT_MAX  = '1;

  state_e            state;
  logic [CNT_W-1:0]  settle_cnt;
  logic [IDX_W-1:0]  cap_idx;
  logic [15:0]       exp_c;
  logic [FLAG_W-1:0] exp_flags;
  logic [FLAG_W-1:0] flag_mask;
  logic              pass;
  logic              busy;
  logic              accept;

  alu_expect_rom u_rom (
    .idx       (cap_idx),
    .exp_c     (exp_c),
    .exp_flags (exp_flags),
    .flag_mask (flag_mask)
  );

  // Out-of-range indices read zeros from the ROM and must still count as failures.
  assign pass = (cap_idx < IDX_W'(NUM_VECTORS)) && (C == exp_c) &&
                (((FLAGS ^ exp_flags) & flag_mask) == '0);

  assign busy   = (state == S_SETTLE) || (state == S_COMPARE);
  assign accept = VEC_STB && ((state != S_DONE) || (VEC_IDX == '0));

  // A strobe landing in the compare cycle abandons that compare, so the pulse is withheld too.
  assign CHECK_STB = (state == S_COMPARE) && !VEC_STB;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= S_IDLE;
      settle_cnt     <= '0;
      cap_idx        <= '0;
      LAST_OK        <= 1'b0;
      PASS_CNT       <= '0;
      FAIL_CNT       <= '0;
      FAIL_SEEN      <= 1'b0;
      FIRST_FAIL_IDX <= '0;
      OVERRUN        <= 1'b0;
      DONE           <= 1'b0;
    end else if (accept) begin
      cap_idx    <= VEC_IDX;
      settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
      state      <= (SETTLE_CYCLES == 1) ? S_COMPARE : S_SETTLE;
      if (busy) OVERRUN <= 1'b1;
      if (state == S_DONE) begin
        PASS_CNT       <= '0;
        FAIL_CNT       <= '0;
        FAIL_SEEN      <= 1'b0;
        FIRST_FAIL_IDX <= '0;
        OVERRUN        <= 1'b0;
        DONE           <= 1'b0;
      end
    end else begin
      case (state)
        S_SETTLE: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt == CNT_W'(1)) state <= S_COMPARE;
        end
        S_COMPARE: begin
          LAST_OK <= pass;
          if (pass) begin
            if (PASS_CNT != CNT_MAX) PASS_CNT <= PASS_CNT + 1'b1;
          end else begin
            if (FAIL_CNT != CNT_MAX) FAIL_CNT <= FAIL_CNT + 1'b1;
            if (!FAIL_SEEN) FIRST_FAIL_IDX <= cap_idx;
            FAIL_SEEN <= 1'b1;
          end
          if (cap_idx == LAST_IDX) begin
            state <= S_DONE;
            DONE  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: transaction-level model checked every cycle plus directed scenarios.
module tb_alu_result_checker;
  import alu_result_checker_pkg::*;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              VEC_STB = 1'b0;
  logic [IDX_W-1:0]  VEC_IDX = '0;
  logic [15:0]       C = '0;
  logic [FLAG_W-1:0] FLAGS = '0;
  logic              CHECK_STB, LAST_OK, FAIL_SEEN, OVERRUN, DONE;
  logic [IDX_W-1:0]  PASS_CNT, FAIL_CNT, FIRST_FAIL_IDX;

  alu_result_checker dut (
    .CLK(CLK), .RESET(RESET), .VEC_STB(VEC_STB), .VEC_IDX(VEC_IDX), .C(C), .FLAGS(FLAGS),
    .CHECK_STB(CHECK_STB), .LAST_OK(LAST_OK), .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT),
    .FAIL_SEEN(FAIL_SEEN), .FIRST_FAIL_IDX(FIRST_FAIL_IDX), .OVERRUN(OVERRUN), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one pending check per strobe, due SETTLE cycles later; stats in plain integers.
  int cyc = 0, due = 0, pidx = 0, stb_count = 0;
  int m_pass = 0, m_fail = 0, m_first = 0;
  bit armed = 0, pend = 0, exp_chk, ok;
  bit m_seen = 0, m_ovr = 0, m_done = 0, m_last = 0;

  always @(negedge CLK) begin
    exp_chk = pend && (due == cyc) && !VEC_STB;
    if (armed) begin
      chk("check_stb", 32'(CHECK_STB), 32'(exp_chk));
      chk("last_ok", 32'(LAST_OK), 32'(m_last));
      chk("pass_cnt", 32'(PASS_CNT), 32'(m_pass));
      chk("fail_cnt", 32'(FAIL_CNT), 32'(m_fail));
      chk("fail_seen", 32'(FAIL_SEEN), 32'(m_seen));
      chk("first_fail_idx", 32'(FIRST_FAIL_IDX), 32'(m_first));
      chk("overrun", 32'(OVERRUN), 32'(m_ovr));
      chk("done", 32'(DONE), 32'(m_done));
    end
    if (CHECK_STB === 1'b1) stb_count++;
    if (RESET) begin
      pend = 0; m_pass = 0; m_fail = 0; m_first = 0;
      m_seen = 0; m_ovr = 0; m_done = 0; m_last = 0; armed = 1;
    end else if (VEC_STB && !(m_done && VEC_IDX != 0)) begin
      if (m_done) begin
        m_pass = 0; m_fail = 0; m_first = 0; m_seen = 0; m_ovr = 0; m_done = 0;
      end
      if (pend) m_ovr = 1;
      pend = 1; pidx = int'(VEC_IDX); due = cyc + DEF_SETTLE_CYCLES;
    end else if (exp_chk) begin
      ok = 0;
      if (pidx < NUM_VECTORS)
        ok = (C == EXP_TABLE[pidx].exp_c) &&
             (((FLAGS ^ EXP_TABLE[pidx].exp_flags) & EXP_TABLE[pidx].flag_mask) == 0);
      m_last = ok;
      if (ok) m_pass = (m_pass < 15) ? m_pass + 1 : 15;
      else begin
        m_fail = (m_fail < 15) ? m_fail + 1 : 15;
        if (!m_seen) m_first = pidx;
        m_seen = 1;
      end
      if (pidx == NUM_VECTORS - 1) m_done = 1;
      pend = 0;
    end
    cyc++;
  end

  task automatic vec(input int idx, input logic [15:0] c, input logic [FLAG_W-1:0] f);
    @(posedge CLK); #1;
    VEC_STB = 1'b1; VEC_IDX = IDX_W'(idx); C = c; FLAGS = f;
    @(posedge CLK); #1;
    VEC_STB = 1'b0;
    repeat (4) @(posedge CLK);
  endtask

  // Golden ALU: drives exactly the expected result for in-range vectors.
  task automatic gvec(input int idx);
    if (idx < NUM_VECTORS) vec(idx, EXP_TABLE[idx].exp_c, EXP_TABLE[idx].exp_flags);
    else vec(idx, 16'h0000, '0);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_check_stb", 32'(CHECK_STB), 0);
    chk("rst_pass_cnt", 32'(PASS_CNT), 0);
    chk("rst_fail_cnt", 32'(FAIL_CNT), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_overrun", 32'(OVERRUN), 0);

    for (int i = 0; i < NUM_VECTORS; i++) gvec(i);
    @(negedge CLK);
    chk("pass1_pass_cnt", 32'(PASS_CNT), 15);
    chk("pass1_fail_cnt", 32'(FAIL_CNT), 0);
    chk("pass1_fail_seen", 32'(FAIL_SEEN), 0);
    chk("pass1_done", 32'(DONE), 1);

    stb_count = 0;
    gvec(5);
    @(negedge CLK);
    chk("done_ignore_stb", 32'(stb_count), 0);
    chk("done_ignore_pass", 32'(PASS_CNT), 15);
    chk("done_ignore_done", 32'(DONE), 1);

    // Restart with faults on index 0 (8 expected) and index 4 (2 expected).
    vec(0, 16'd9, '0);
    @(negedge CLK);
    chk("restart_pass_cnt", 32'(PASS_CNT), 0);
    chk("restart_fail_cnt", 32'(FAIL_CNT), 1);
    chk("restart_done", 32'(DONE), 0);
    for (int i = 1; i < 4; i++) gvec(i);
    vec(4, 16'd1, '0);
    @(negedge CLK);
    chk("fault_last_ok_idx4", 32'(LAST_OK), 0);
    for (int i = 5; i < NUM_VECTORS; i++) gvec(i);
    @(negedge CLK);
    chk("fault_fail_cnt", 32'(FAIL_CNT), 2);
    chk("fault_pass_cnt", 32'(PASS_CNT), 13);
    chk("fault_first_idx", 32'(FIRST_FAIL_IDX), 0);
    chk("fault_fail_seen", 32'(FAIL_SEEN), 1);
    chk("fault_done", 32'(DONE), 1);

    // Flag mask on XOR: Z is checked, C is masked out.
    gvec(0);
    vec(2, 16'h0000, '0);
    @(negedge CLK);
    chk("mask_z_last_ok", 32'(LAST_OK), 0);
    chk("mask_z_fail_cnt", 32'(FAIL_CNT), 1);
    chk("mask_z_first_idx", 32'(FIRST_FAIL_IDX), 2);
    vec(2, 16'h0000, F_Z | F_C);
    @(negedge CLK);
    chk("mask_c_last_ok", 32'(LAST_OK), 1);
    chk("mask_c_pass_cnt", 32'(PASS_CNT), 2);

    // Overrun: idx 3 then idx 4 two cycles later; only idx 4 is checked.
    stb_count = 0;
    @(posedge CLK); #1;
    VEC_STB = 1'b1; VEC_IDX = 4'd3; C = EXP_TABLE[3].exp_c; FLAGS = EXP_TABLE[3].exp_flags;
    @(posedge CLK); #1 VEC_STB = 1'b0;
    @(posedge CLK); #1;
    VEC_STB = 1'b1; VEC_IDX = 4'd4; C = EXP_TABLE[4].exp_c; FLAGS = EXP_TABLE[4].exp_flags;
    @(posedge CLK); #1 VEC_STB = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    chk("overrun_flag", 32'(OVERRUN), 1);
    chk("overrun_stb_count", 32'(stb_count), 1);
    chk("overrun_pass_cnt", 32'(PASS_CNT), 3);

    gvec(15);
    @(negedge CLK);
    chk("oor_fail_cnt", 32'(FAIL_CNT), 2);
    chk("oor_done", 32'(DONE), 0);

    for (int i = 0; i < 16; i++) gvec(15);
    @(negedge CLK);
    chk("sat_fail_cnt", 32'(FAIL_CNT), 15);

    // Reset while settling must suppress the check.
    stb_count = 0;
    @(posedge CLK); #1;
    VEC_STB = 1'b1; VEC_IDX = 4'd5; C = EXP_TABLE[5].exp_c; FLAGS = EXP_TABLE[5].exp_flags;
    @(posedge CLK); #1 VEC_STB = 1'b0;
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    chk("rst_settle_stb_count", 32'(stb_count), 0);
    chk("rst_settle_fail_cnt", 32'(FAIL_CNT), 0);
    chk("rst_settle_pass_cnt", 32'(PASS_CNT), 0);
    chk("rst_settle_overrun", 32'(OVERRUN), 0);
    chk("rst_settle_fail_seen", 32'(FAIL_SEEN), 0);
    chk("rst_settle_last_ok", 32'(LAST_OK), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
